// File: rtl/spi_rx_deser_pkg.sv
// Shared types and default constants for the SPI mode-0 receive deserializer.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned DSIZE_DEF       = 8;
  localparam int unsigned MAX_BYTES_DEF   = 15;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Width of a counter able to hold 0..max_bytes.
  function automatic int unsigned cnt_w(input int unsigned max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage

// File: rtl/spi_rx_deser_if.sv
// FIFO write-side handshake between the deserializer (master) and the FIFO (slave).
interface spi_rx_deser_if
  import spi_rx_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
) ();

  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             fifo_full;

  modport master (output wdata, output winc, input fifo_full);
  modport slave  (input wdata, input winc, output fifo_full);

endinterface

// File: rtl/spi_rx_deser_sync_ff.sv
// Multi-flop bit synchronizer with a configurable reset level.
module sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_rx_deser.sv
// SPI mode-0 slave receive deserializer: samples raw pins in the clk domain,
// assembles DSIZE-bit bytes and pushes them to a FIFO, with per-frame status.
module spi_rx_deser
  import spi_rx_pkg::*;
#(
  parameter int unsigned DSIZE       = DSIZE_DEF,
  parameter int unsigned MAX_BYTES   = MAX_BYTES_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sclk,
  input  logic                           cs_n,
  input  logic                           mosi,
  spi_rx_deser_if.master                 fifo,
  output logic [cnt_w(MAX_BYTES)-1:0]    byte_cnt,
  output logic                           frame_done,
  output logic                           ovf,
  output logic                           frame_err
);

  localparam int unsigned BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam int unsigned CW = cnt_w(MAX_BYTES);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic sclk_rise, cs_fall, cs_rise, mosi_q;
  logic fall_pend;
  logic byte_end, can_push;
  logic [BW-1:0]    bit_cnt;
  logic [DSIZE-1:0] shreg, sh_next;
  state_t state_q, state_d;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs_n), .q(cs_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

  // Edge strobes are registered; mosi is delayed alongside so it stays aligned with sclk_rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      sclk_rise <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      sclk_rise <= sclk_s & ~sclk_d;
      cs_fall   <= ~cs_s & cs_d;
      cs_rise   <= cs_s & ~cs_d;
      mosi_q    <= mosi_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sh_next  = MSB_FIRST ? {shreg[DSIZE-2:0], mosi_q} : {mosi_q, shreg[DSIZE-1:1]};
    byte_end = (state_q == ACTIVE) && sclk_rise && (bit_cnt == BW'(DSIZE - 1));
    can_push = !fifo.fifo_full && (byte_cnt < CW'(MAX_BYTES));
    case (state_q)
      IDLE:    if (cs_fall || fall_pend) state_d = ACTIVE;
      ACTIVE:  if (cs_rise)              state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A cs_n fall seen in DONE is remembered for one cycle so IDLE can act on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo.wdata <= '0;
      fifo.winc  <= 1'b0;
      byte_cnt   <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      fall_pend  <= 1'b0;
    end else begin
      fifo.winc  <= 1'b0;
      frame_done <= 1'b0;
      fall_pend  <= (state_q == DONE) && cs_fall;
      case (state_q)
        IDLE: begin
          if (cs_fall || fall_pend) begin
            byte_cnt  <= '0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            shreg <= sh_next;
            if (byte_end) begin
              bit_cnt    <= '0;
              fifo.wdata <= sh_next;
              if (can_push) begin
                fifo.winc <= 1'b1;
                byte_cnt  <= byte_cnt + 1'b1;
              end else begin
                ovf <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          if (bit_cnt != '0) frame_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: table of frames plus reset/flag-clear/bit-order sequences.
module tb_spi_rx_deser;
  import spi_rx_pkg::*;

  logic clk = 1'b0;
  logic rst, sclk, cs_n, mosi, fifo_full;
  logic [3:0] byte_cnt, l_byte_cnt;
  logic frame_done, ovf, frame_err;
  logic l_frame_done, l_ovf, l_frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  logic prev_winc = 1'b0;
  logic [7:0] lsb_last = '0;
  logic [7:0] push_q[$];

  always #5 clk = ~clk;

  spi_rx_deser_if #(.DSIZE(8)) fif ();
  spi_rx_deser_if #(.DSIZE(8)) fif_l ();
  assign fif.fifo_full   = fifo_full;
  assign fif_l.fifo_full = fifo_full;

  spi_rx_deser #(.DSIZE(8), .MAX_BYTES(15), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .fifo(fif.master), .byte_cnt(byte_cnt), .frame_done(frame_done),
    .ovf(ovf), .frame_err(frame_err)
  );

  spi_rx_deser #(.DSIZE(8), .MAX_BYTES(15), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .fifo(fif_l.master), .byte_cnt(l_byte_cnt), .frame_done(l_frame_done),
    .ovf(l_ovf), .frame_err(l_frame_err)
  );

  typedef struct {
    logic [7:0]  b0, b1;
    int unsigned nbytes, full_idx, extra_bits, exp_pushes;
    logic [3:0]  exp_cnt;
    logic        exp_ovf, exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fif.winc) begin
      push_q.push_back(fif.wdata);
      n_checks++;
      if (prev_winc) begin
        n_fail++;
        $display("FAIL winc_spacing: got back-to-back winc expected gap");
      end
    end
    prev_winc = fif.winc;
    if (frame_done) fd_cnt++;
    if (fif_l.winc) lsb_last = fif_l.wdata;
  end

  task automatic send_bit(input logic b);
    @(negedge clk) mosi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic full);
    fifo_full = full;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    fifo_full = 1'b0;
  endtask

  task automatic start_frame();
    push_q.delete();
    fd_cnt = 0;
    @(negedge clk) cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  function automatic logic [7:0] byte_of(input vec_t v, input int unsigned i);
    if (i == 0) return v.b0;
    if (i == 1) return v.b1;
    return 8'(i);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  exp_q[$];
    int unsigned acc;
    //          b0     b1     n   full ext pushes cnt   ovf   err
    vecs[0] = '{8'hA5, 8'h3C, 2,  99,  0,  2,     4'd2,  1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 16, 99,  0,  15,    4'd15, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 8'h22, 3,  1,   0,  2,     4'd2,  1'b1, 1'b0};
    vecs[3] = '{8'hC3, 8'h96, 1,  99,  5,  1,     4'd1,  1'b0, 1'b1};

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wdata", fif.wdata, 8'h00);
    check("rst_winc", fif.winc, 1'b0);
    check("rst_byte_cnt", byte_cnt, 4'd0);
    check("rst_flags", {frame_done, ovf, frame_err}, 3'b000);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      exp_q.delete();
      acc = 0;
      start_frame();
      for (int unsigned i = 0; i < vecs[v].nbytes; i++) begin
        send_byte(byte_of(vecs[v], i), i == vecs[v].full_idx);
        if (i != vecs[v].full_idx && acc < 15) begin
          exp_q.push_back(byte_of(vecs[v], i));
          acc++;
        end
      end
      for (int unsigned i = 0; i < vecs[v].extra_bits; i++) send_bit(1'b1);
      end_frame();
      check($sformatf("v%0d_npush", v), push_q.size(), vecs[v].exp_pushes);
      check($sformatf("v%0d_model_npush", v), exp_q.size(), vecs[v].exp_pushes);
      for (int i = 0; i < exp_q.size() && i < push_q.size(); i++)
        check($sformatf("v%0d_wdata%0d", v, i), push_q[i], exp_q[i]);
      check($sformatf("v%0d_byte_cnt", v), byte_cnt, vecs[v].exp_cnt);
      check($sformatf("v%0d_ovf", v), ovf, vecs[v].exp_ovf);
      check($sformatf("v%0d_frame_err", v), frame_err, vecs[v].exp_err);
      check($sformatf("v%0d_frame_done_cnt", v), fd_cnt, 1);
    end

    // Flags from the errored frame are cleared by the next cs_n fall.
    start_frame();
    repeat (4) @(negedge clk);
    check("clr_frame_err", frame_err, 1'b0);
    check("clr_byte_cnt", byte_cnt, 4'd0);
    check("clr_ovf", ovf, 1'b0);
    end_frame();
    check("empty_frame_err", frame_err, 1'b0);
    check("empty_frame_done_cnt", fd_cnt, 1);

    // Bit stream 1,0,0,0,0,0,0,0 into both bit orders.
    start_frame();
    send_byte(8'h80, 1'b0);
    end_frame();
    check("msb_first_wdata", push_q.size() > 0 ? push_q[0] : 8'hXX, 8'h80);
    check("lsb_first_wdata", lsb_last, 8'h01);

    // Reset in the middle of a byte discards it.
    start_frame();
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    @(negedge clk) begin rst = 1'b1; cs_n = 1'b1; end
    @(negedge clk);
    check("midrst_wdata", fif.wdata, 8'h00);
    check("midrst_byte_cnt", byte_cnt, 4'd0);
    check("midrst_flags", {fif.winc, frame_done, ovf, frame_err}, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_push", push_q.size(), 0);
    start_frame();
    send_byte(8'h5A, 1'b0);
    end_frame();
    check("post_rst_npush", push_q.size(), 1);
    check("post_rst_wdata", push_q.size() > 0 ? push_q[0] : 8'hXX, 8'h5A);
    check("post_rst_byte_cnt", byte_cnt, 4'd1);
    check("post_rst_frame_err", frame_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
